// File: rtl/ysyx_bus_rr_arbiter.sv
// rtl/ysyx_bus_rr_arbiter.sv - round-robin arbiter from NUM_M simple masters onto one AXI4 port
//
// Purpose: grants one simple load/store master at a time and runs a
// single-beat AXI4 read or write on its behalf. At most one transaction is
// outstanding. Completion is reported with a one-cycle m_rvalid pulse to the
// owning master.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m_valid/m_write           per-master request and direction (1 = store)
//   m_addr/m_wdata/m_wstrb    packed per-master address, store data, byte strobes
//   m_size                    packed per-master AXI size codes
//   m_ready                   one-cycle accept pulse to the granted master
//   m_rvalid/m_rdata/m_err    completion pulse, load data, error flag
//   io_master_ar*/r*          AXI4 read address / read data channels
//   io_master_aw*/w*/b*       AXI4 write address / write data / write response
//
// Optional feature: define YSYX_BUS_TIMEOUT_EN to abort a transaction that
// has spent TIMEOUT cycles outside IDLE, completing it with m_err = 1.

module ysyx_bus_rr_arbiter #(
  parameter int NUM_M   = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         m_valid,
  input  logic [NUM_M-1:0]         m_write,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata,
  input  logic [NUM_M*4-1:0]       m_wstrb,
  input  logic [NUM_M*3-1:0]       m_size,
  output logic [NUM_M-1:0]         m_ready,
  output logic [NUM_M-1:0]         m_rvalid,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     m_err,
  output logic [ADDR_W-1:0]        io_master_araddr,
  output logic [2:0]               io_master_arsize,
  output logic [7:0]               io_master_arlen,
  output logic [1:0]               io_master_arburst,
  output logic [3:0]               io_master_arid,
  output logic                     io_master_arvalid,
  input  logic                     io_master_arready,
  input  logic [63:0]              io_master_rdata,
  input  logic [1:0]               io_master_rresp,
  input  logic                     io_master_rlast,
  input  logic [3:0]               io_master_rid,
  input  logic                     io_master_rvalid,
  output logic                     io_master_rready,
  output logic [ADDR_W-1:0]        io_master_awaddr,
  output logic [2:0]               io_master_awsize,
  output logic [7:0]               io_master_awlen,
  output logic [1:0]               io_master_awburst,
  output logic [3:0]               io_master_awid,
  output logic                     io_master_awvalid,
  input  logic                     io_master_awready,
  output logic [63:0]              io_master_wdata,
  output logic [7:0]               io_master_wstrb,
  output logic                     io_master_wlast,
  output logic                     io_master_wvalid,
  input  logic                     io_master_wready,
  input  logic [1:0]               io_master_bresp,
  input  logic [3:0]               io_master_bid,
  input  logic                     io_master_bvalid,
  output logic                     io_master_bready
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     rr_ptr, g_q, gnt_idx;
  logic [IW:0]       arb_sum;
  logic              gnt_found, grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        strb_q;
  logic [2:0]        size_q;
  logic              aw_done, w_done, aw_done_nx, w_done_nx;
  logic              cpl, cpl_err;
  logic [31:0]       cpl_data;
  logic              tmo_hit;
  logic [31:0]       wdata32;
  logic [3:0]        strb4;
  logic              unused_ok;

  // rid/bid/rlast carry nothing we act on: one transaction is outstanding.
  assign unused_ok = ^{io_master_rlast, io_master_rid, io_master_bid};

  // First requester at or after rr_ptr, wrapping NUM_M-1 -> 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_sum   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      arb_sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (arb_sum >= (IW+1)'(NUM_M)) arb_sum = arb_sum - (IW+1)'(NUM_M);
      if (!gnt_found && m_valid[arb_sum[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = arb_sum[IW-1:0];
      end
    end
  end

  // No grant in the IDLE cycle that publishes a completion, so a zero-wait
  // load spans IDLE, RADDR, RDATA, IDLE before the next grant.
  assign grant = (state == IDLE) && gnt_found && !(|m_rvalid);

  always_comb begin
    m_ready = '0;
    if (grant) m_ready[gnt_idx] = 1'b1;
  end

`ifdef YSYX_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  // Counts cycles since the grant; the abort fires in the TIMEOUT-th cycle
  // after entering RADDR/WADDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tmo_cnt <= '0;
    else if (grant)          tmo_cnt <= '0;
    else if (state != IDLE)  tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;
    cpl        = 1'b0;
    cpl_err    = 1'b0;
    cpl_data   = '0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nx   = m_write[gnt_idx] ? WADDR : RADDR;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
        end
      end
      RADDR: if (io_master_arready) state_nx = RDATA;
      RDATA: begin
        if (io_master_rvalid) begin
          cpl      = 1'b1;
          cpl_err  = |io_master_rresp;
          cpl_data = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
          state_nx = IDLE;
        end
      end
      WADDR: begin
        // AW and W complete independently; move on once both have.
        aw_done_nx = aw_done | io_master_awready;
        w_done_nx  = w_done | io_master_wready;
        if (aw_done_nx && w_done_nx) state_nx = WRESP;
      end
      WRESP: begin
        if (io_master_bvalid) begin
          cpl      = 1'b1;
          cpl_err  = |io_master_bresp;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (tmo_hit) begin
      state_nx = IDLE;
      cpl      = 1'b1;
      cpl_err  = 1'b1;
      cpl_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      g_q      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      size_q   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      m_rvalid <= '0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
    end else begin
      state    <= state_nx;
      aw_done  <= aw_done_nx;
      w_done   <= w_done_nx;
      m_rvalid <= '0;
      m_err    <= 1'b0;
      if (grant) begin
        g_q     <= gnt_idx;
        addr_q  <= m_addr[gnt_idx*ADDR_W +: ADDR_W];
        wdata_q <= m_wdata[gnt_idx*DATA_W +: DATA_W];
        strb_q  <= m_wstrb[gnt_idx*4 +: 4];
        size_q  <= m_size[gnt_idx*3 +: 3];
      end
      if (cpl) begin
        m_rvalid[g_q] <= 1'b1;
        m_err         <= cpl_err;
        m_rdata       <= DATA_W'(cpl_data);
        rr_ptr        <= (g_q == IW'(NUM_M - 1)) ? '0 : g_q + 1'b1;
      end
    end
  end

  // Store data sits at its byte offset and is mirrored on both halves so
  // the slave picks the correct half through the strobes.
  assign wdata32 = 32'(wdata_q) << {addr_q[1:0], 3'b000};
  assign strb4   = strb_q << addr_q[1:0];

  assign io_master_araddr  = addr_q;
  assign io_master_arsize  = size_q;
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;
  assign io_master_arid    = 4'(g_q);
  assign io_master_arvalid = (state == RADDR);
  assign io_master_rready  = (state == RDATA);

  assign io_master_awaddr  = addr_q;
  assign io_master_awsize  = size_q;
  assign io_master_awlen   = 8'd0;
  assign io_master_awburst = 2'b01;
  assign io_master_awid    = 4'(g_q);
  assign io_master_awvalid = (state == WADDR) && !aw_done;
  assign io_master_wvalid  = (state == WADDR) && !w_done;
  assign io_master_wlast   = io_master_wvalid;
  assign io_master_wdata   = {wdata32, wdata32};
  assign io_master_wstrb   = addr_q[2] ? {strb4, 4'h0} : {4'h0, strb4};
  assign io_master_bready  = (state == WRESP);

endmodule

// File: tb/tb_ysyx_bus_rr_arbiter.sv
// tb/tb_ysyx_bus_rr_arbiter.sv - scoreboard bench for ysyx_bus_rr_arbiter
module tb_ysyx_bus_rr_arbiter;
  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef YSYX_BUS_TIMEOUT_EN
  localparam int TO = 15;
`else
  localparam int TO = 1023;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_valid, m_write, m_ready, m_rvalid;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*4-1:0]  m_wstrb;
  logic [NM*3-1:0]  m_size;
  logic [DW-1:0]    m_rdata;
  logic             m_err;
  logic [AW-1:0]    io_master_araddr, io_master_awaddr;
  logic [2:0]       io_master_arsize, io_master_awsize;
  logic [7:0]       io_master_arlen, io_master_awlen, io_master_wstrb;
  logic [1:0]       io_master_arburst, io_master_awburst, io_master_rresp, io_master_bresp;
  logic [3:0]       io_master_arid, io_master_awid, io_master_rid, io_master_bid;
  logic             io_master_arvalid, io_master_arready, io_master_rlast, io_master_rvalid;
  logic             io_master_rready, io_master_awvalid, io_master_awready, io_master_wlast;
  logic             io_master_wvalid, io_master_wready, io_master_bvalid, io_master_bready;
  logic [63:0]      io_master_rdata, io_master_wdata;

  ysyx_bus_rr_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_size(m_size), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_err(m_err),
    .io_master_araddr(io_master_araddr), .io_master_arsize(io_master_arsize),
    .io_master_arlen(io_master_arlen), .io_master_arburst(io_master_arburst),
    .io_master_arid(io_master_arid), .io_master_arvalid(io_master_arvalid),
    .io_master_arready(io_master_arready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_awaddr(io_master_awaddr), .io_master_awsize(io_master_awsize),
    .io_master_awlen(io_master_awlen), .io_master_awburst(io_master_awburst),
    .io_master_awid(io_master_awid), .io_master_awvalid(io_master_awvalid),
    .io_master_awready(io_master_awready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast), .io_master_wvalid(io_master_wvalid),
    .io_master_wready(io_master_wready),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready)
  );

  typedef struct {
    int          m;
    logic [31:0] d;
    logic        e;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];
  int   cpl_cycs[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, last_gnt_cyc = 0, cur_m = 0, exp_ptr = 0, bready_cyc = 0;
  logic [31:0] addr_of [NM];
  logic [63:0] last_wdata;
  logic [7:0]  last_wstrb;
  logic        last_wlast, cpl_arvalid;
  logic [NM-1:0] rdy_seen;

  // slave model knobs
  bit          ar_en = 1'b1, r_stall = 1'b0, use_fixed = 1'b0;
  logic [63:0] fixed_rdata = '0;
  logic [1:0]  r_resp = '0, b_resp = '0;
  int          aw_lat = 0, w_lat = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] last_araddr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] slv_data(input logic [31:0] a);
    return use_fixed ? fixed_rdata : {a ^ 32'h5a5a_5a5a, a};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [63:0] v;
    v = slv_data(a);
    return a[2] ? v[63:32] : v[31:0];
  endfunction

  task automatic slave();
    io_master_arready = ar_en;
    io_master_rvalid  = io_master_rready && !r_stall;
    io_master_rdata   = slv_data(last_araddr);
    io_master_rresp   = r_resp;
    io_master_rlast   = 1'b1;
    io_master_rid     = '0;
    if (io_master_awvalid) begin io_master_awready = (aw_cnt >= aw_lat); aw_cnt++; end
    else begin io_master_awready = 1'b0; aw_cnt = 0; end
    if (io_master_wvalid) begin io_master_wready = (w_cnt >= w_lat); w_cnt++; end
    else begin io_master_wready = 1'b0; w_cnt = 0; end
    io_master_bvalid = io_master_bready;
    io_master_bresp  = b_resp;
    io_master_bid    = '0;
  endtask

  task automatic monitor();
    int   g;
    exp_t e;
    if (|m_ready) begin
      if (gnt_q.size() == 0) check("unexpected_grant", 64'(m_ready), 64'd0);
      else begin
        g = gnt_q.pop_front();
        check("grant", 64'(m_ready), 64'd1 << g);
        cur_m = g;
        last_gnt_cyc = cyc;
      end
    end
    if (io_master_arvalid && io_master_arready) begin
      check("araddr", 64'(io_master_araddr), 64'(addr_of[cur_m]));
      check("arid", 64'(io_master_arid), 64'(cur_m));
      check("arlen_burst", 64'({io_master_arlen, io_master_arburst}), 64'({8'd0, 2'b01}));
      last_araddr = io_master_araddr;
    end
    if (io_master_awvalid && io_master_awready)
      check("awaddr", 64'(io_master_awaddr), 64'(addr_of[cur_m]));
    if (io_master_wvalid && io_master_wready) begin
      last_wdata = io_master_wdata;
      last_wstrb = io_master_wstrb;
      last_wlast = io_master_wlast;
    end
    if (io_master_bready) bready_cyc++;
    if (|m_rvalid) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 64'(m_rvalid), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("rvalid_owner", 64'(m_rvalid), 64'd1 << e.m);
        check("rdata", 64'(m_rdata), 64'(e.d));
        check("err", 64'(m_err), 64'(e.e));
        if (e.lat > 0) check("latency", 64'(cyc - last_gnt_cyc), 64'(e.lat));
        cpl_cycs.push_back(cyc);
        cpl_arvalid = io_master_arvalid;
        exp_ptr = (e.m + 1) % NM;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    rdy_seen = m_ready;
    @(posedge clk);
    #1;
    cyc++;
    m_valid = m_valid & ~rdy_seen;
    slave();
  endtask

  task automatic issue(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit push, input logic [31:0] ed,
                       input logic ee, input int lat);
    m_valid[m] = 1'b1;
    m_write[m] = wr;
    m_addr[m*AW +: AW] = a;
    m_wdata[m*DW +: DW] = d;
    m_wstrb[m*4 +: 4] = s;
    m_size[m*3 +: 3] = 3'd2;
    addr_of[m] = a;
    if (push) exp_q.push_back('{m, ed, ee, lat});
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin step(); n++; end
    check("drain", 64'(exp_q.size()), 64'd0);
    check("grants_left", 64'(gnt_q.size()), 64'd0);
    step();
    step();
  endtask

  // All masters request loads together; grants follow the modelled pointer.
  task automatic all3(input logic [31:0] base);
    int m;
    for (int i = 0; i < NM; i++) begin
      m = (exp_ptr + i) % NM;
      gnt_q.push_back(m);
      issue(m, 1'b0, base + 32'(4*m), 32'h0, 4'hf, 1'b1, exp_rd(base + 32'(4*m)), 1'b0, 3);
    end
  endtask

  initial begin
    int n;
    m_valid = '0; m_write = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_size = '0;
    io_master_arready = 0; io_master_rvalid = 0; io_master_rdata = '0; io_master_rresp = '0;
    io_master_rlast = 0; io_master_rid = '0; io_master_awready = 0; io_master_wready = 0;
    io_master_bvalid = 0; io_master_bresp = '0; io_master_bid = '0;
    rst = 1'b1;
    #12;
    check("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_m_err", 64'(m_err), 64'd0);
    check("rst_m_rdata", 64'(m_rdata), 64'd0);
    check("rst_bus_valids", 64'({io_master_arvalid, io_master_awvalid, io_master_wvalid,
                                 io_master_rready, io_master_bready}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    slave();

    // three loads together: order 0,1,2, completions 4 cycles apart
    cpl_cycs.delete();
    all3(32'h8000_0000);
    drain(60);
    check("cpl_count", 64'(cpl_cycs.size()), 64'd3);
    if (cpl_cycs.size() == 3) begin
      check("gap01", 64'(cpl_cycs[1] - cpl_cycs[0]), 64'd4);
      check("gap12", 64'(cpl_cycs[2] - cpl_cycs[1]), 64'd4);
    end

    // upper / lower half selection, wrap of the pointer to master 0
    use_fixed = 1'b1;
    fixed_rdata = 64'h1122_3344_5566_7788;
    gnt_q.push_back(1);
    issue(1, 1'b0, 32'h8000_0004, 32'h0, 4'hf, 1'b1, 32'h1122_3344, 1'b0, 3);
    drain(20);
    gnt_q.push_back(0);
    issue(0, 1'b0, 32'h8000_0000, 32'h0, 4'hf, 1'b1, 32'h5566_7788, 1'b0, 3);
    drain(20);
    use_fixed = 1'b0;

    // byte store at offset 3, W accepted two cycles after AW
    w_lat = 2;
    bready_cyc = 0;
    gnt_q.push_back(2);
    issue(2, 1'b1, 32'h8000_0003, 32'h0000_00ab, 4'h1, 1'b1, 32'h0, 1'b0, 5);
    drain(20);
    check("st1_wstrb", 64'(last_wstrb), 64'h08);
    check("st1_wdata", last_wdata, 64'hab00_0000_ab00_0000);
    check("st1_wlast", 64'(last_wlast), 64'd1);
    check("st1_wresp_entries", 64'(bready_cyc), 64'd1);
    w_lat = 0;

    // halfword store in upper lane with an error response
    b_resp = 2'b10;
    gnt_q.push_back(0);
    issue(0, 1'b1, 32'h8000_0006, 32'h0000_1234, 4'h3, 1'b1, 32'h0, 1'b1, 3);
    drain(20);
    check("st2_wstrb", 64'(last_wstrb), 64'hc0);
    check("st2_wdata", last_wdata, 64'h1234_0000_1234_0000);
    b_resp = 2'b00;

    // load with an error response
    r_resp = 2'b11;
    gnt_q.push_back(1);
    issue(1, 1'b0, 32'h8000_0010, 32'h0, 4'hf, 1'b1, exp_rd(32'h8000_0010), 1'b1, 3);
    drain(20);
    r_resp = 2'b00;

    // pointer now 2: all requesting grants 2,0,1
    all3(32'h8000_0100);
    drain(60);

    // a request withdrawn before its grant is ignored
    gnt_q.push_back(2);
    issue(2, 1'b0, 32'h8000_0200, 32'h0, 4'hf, 1'b1, exp_rd(32'h8000_0200), 1'b0, 3);
    step();
    issue(0, 1'b0, 32'h8000_0300, 32'h0, 4'hf, 1'b0, 32'h0, 1'b0, 0);
    step();
    m_valid[0] = 1'b0;
    drain(20);

    // reset while waiting for read data abandons the load
    r_stall = 1'b1;
    gnt_q.push_back(0);
    issue(0, 1'b0, 32'h8000_0400, 32'h0, 4'hf, 1'b0, 32'h0, 1'b0, 0);
    n = 0;
    while (!io_master_rready && n < 10) begin step(); n++; end
    check("reach_rdata", 64'(io_master_rready), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_rdata_rready", 64'(io_master_rready), 64'd0);
    check("rst_rdata_outputs", 64'({m_rvalid, m_err, m_ready}), 64'd0);
    check("rst_rdata_m_rdata", 64'(m_rdata), 64'd0);
    m_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    r_stall = 1'b0;
    exp_ptr = 0;
    slave();
    repeat (8) step();

    // pointer back at 0 after reset
    all3(32'h8000_0500);
    drain(60);

`ifdef YSYX_BUS_TIMEOUT_EN
    ar_en = 1'b0;
    gnt_q.push_back(exp_ptr);
    issue(exp_ptr, 1'b0, 32'h8000_0600, 32'h0, 4'hf, 1'b1, 32'h0, 1'b1, TO + 1);
    drain(60);
    check("tmo_arvalid", 64'(cpl_arvalid), 64'd0);
    ar_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
